// File: rtl/multi_gate_delay_gen.sv
// multi_gate_delay_gen: trigger-launched burst of n_rep periods, each with one gate per channel
// at its own delay and width, plus arming, abort, retrigger, post-burst hold-off and missed flag.
module multi_gate_delay_gen #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int REP_W   = 16,
  parameter int HOLDOFF = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic                  retrig_en,
  input  logic                  missed_clr,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic [N_CH*CNT_W-1:0] width,
  input  logic [CNT_W-1:0]      period,
  input  logic [REP_W-1:0]      n_rep,
  output logic [N_CH-1:0]       pulse,
  output logic                  busy,
  output logic [REP_W-1:0]      rep_idx,
  output logic                  done,
  output logic                  missed
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic trig_d, accept, start, set_missed, wrap, last, hold_end;
  logic [CNT_W-1:0] cnt, period_sh;
  logic [REP_W-1:0] rep, nrep_sh;
  logic [N_CH*CNT_W-1:0] delay_sh, width_sh;
  logic [HW-1:0] hcnt;
  logic [N_CH-1:0] window;
  assign accept     = trigger & ~trig_d & arm & ~abort;
  assign start      = accept & (state == IDLE | (state == RUN & retrig_en));
  assign set_missed = accept & ((state == RUN & ~retrig_en) | state == HOLD);
  assign wrap       = cnt == period_sh - 1'b1;
  assign last       = wrap & (rep == nrep_sh - 1'b1);
  assign hold_end   = hcnt == HW'(HOLDOFF - 1);
  // window end is formed one bit wider so delay+width never wraps
  for (genvar i = 0; i < N_CH; i++) begin : g_win
    assign window[i] = ({1'b0, cnt} >= {1'b0, delay_sh[i*CNT_W +: CNT_W]}) &&
                       ({1'b0, cnt} < {1'b0, delay_sh[i*CNT_W +: CNT_W]} + {1'b0, width_sh[i*CNT_W +: CNT_W]});
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = abort                   ? IDLE :
               start                   ? RUN :
               (state == RUN && last)  ? (HOLDOFF > 0 ? HOLD : IDLE) :
               (state == HOLD && hold_end) ? IDLE : state;
  end
  always_comb begin
    busy    = state != IDLE;
    rep_idx = rep;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      delay_sh  <= '0;
      width_sh  <= '0;
      period_sh <= CNT_W'(1);
      nrep_sh   <= REP_W'(1);
    end else if (start) begin
      delay_sh  <= delay;
      width_sh  <= width;
      period_sh <= period == '0 ? CNT_W'(1) : period;
      nrep_sh   <= n_rep == '0 ? REP_W'(1) : n_rep;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      trig_d <= trigger;
      cnt    <= '0;
      rep    <= '0;
      hcnt   <= '0;
      pulse  <= '0;
      done   <= 1'b0;
      missed <= 1'b0;
    end else begin
      trig_d <= trigger;
      pulse  <= state == RUN ? window : '0;
      done   <= ~abort & ~start & (state == RUN) & last;
      missed <= set_missed | (missed & ~missed_clr);
      hcnt   <= state == HOLD ? hcnt + 1'b1 : '0;
      if (abort || start || state != RUN || last) begin
        cnt <= '0;
        rep <= '0;
      end else if (wrap) begin
        cnt <= '0;
        rep <= rep + 1'b1;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_multi_gate_delay_gen.sv
// tb_multi_gate_delay_gen: two instances (HOLDOFF 0 and 4) checked cycle by cycle against
// an elapsed-time reference model, plus directed known-answer checks per scenario.
module tb_multi_gate_delay_gen;
  localparam int N = 4, CW = 32, RW = 16;
  logic clk = 1'b0;
  logic rst_n, arm, trigger, abort, retrig_en, missed_clr;
  logic [N*CW-1:0] delay, width;
  logic [CW-1:0] period;
  logic [RW-1:0] n_rep;
  logic [N-1:0] pulse_o [2];
  logic busy_o [2], done_o [2], missed_o [2];
  logic [RW-1:0] rep_o [2];
  logic [22:0] got_v [2];
  int tests, fails;
  longint cyc;
  logic trig_prev;
  int m_mode [2];
  longint m_t0 [2], m_hend [2], m_p [2], m_n [2], m_rep [2];
  longint m_d [2][N], m_w [2][N];
  logic [N-1:0] m_pulse [2];
  logic m_done [2], m_missed [2];

  always #5 clk = ~clk;

  multi_gate_delay_gen #(.N_CH(N), .CNT_W(CW), .REP_W(RW), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .abort(abort),
    .retrig_en(retrig_en), .missed_clr(missed_clr), .delay(delay), .width(width),
    .period(period), .n_rep(n_rep), .pulse(pulse_o[0]), .busy(busy_o[0]),
    .rep_idx(rep_o[0]), .done(done_o[0]), .missed(missed_o[0]));

  multi_gate_delay_gen #(.N_CH(N), .CNT_W(CW), .REP_W(RW), .HOLDOFF(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .abort(abort),
    .retrig_en(retrig_en), .missed_clr(missed_clr), .delay(delay), .width(width),
    .period(period), .n_rep(n_rep), .pulse(pulse_o[1]), .busy(busy_o[1]),
    .rep_idx(rep_o[1]), .done(done_o[1]), .missed(missed_o[1]));

  assign got_v[0] = {pulse_o[0], busy_o[0], rep_o[0], done_o[0], missed_o[0]};
  assign got_v[1] = {pulse_o[1], busy_o[1], rep_o[1], done_o[1], missed_o[1]};

  function automatic logic [22:0] exp_v(int h);
    return {m_pulse[h], m_mode[h] != 0, RW'(m_rep[h]), m_done[h], m_missed[h]};
  endfunction

  // Reference: burst position is derived from cycles elapsed since the accepting edge.
  task automatic model_edge();
    logic te;
    bit run, fin, st, sm;
    longint el, c;
    logic [N-1:0] pn;
    cyc++;
    te = trigger & ~trig_prev;
    trig_prev = trigger;
    for (int h = 0; h < 2; h++) begin
      if (!rst_n) begin
        m_mode[h] = 0; m_pulse[h] = '0; m_done[h] = 0; m_missed[h] = 0; m_rep[h] = 0;
        continue;
      end
      run = m_mode[h] == 1;
      el = cyc - m_t0[h] - 1;
      c = run ? el % m_p[h] : 0;
      for (int i = 0; i < N; i++) pn[i] = run && c >= m_d[h][i] && c < m_d[h][i] + m_w[h][i];
      fin = run && el == m_p[h] * m_n[h] - 1;
      st = !abort && te && arm && (m_mode[h] == 0 || (run && retrig_en));
      sm = !abort && te && arm && ((run && !retrig_en) || m_mode[h] == 2);
      m_done[h] = fin && !abort && !st;
      m_pulse[h] = pn;
      if (sm) m_missed[h] = 1;
      else if (missed_clr) m_missed[h] = 0;
      if (abort) m_mode[h] = 0;
      else if (st) begin
        m_mode[h] = 1;
        m_t0[h] = cyc;
        m_p[h] = period == 0 ? 1 : longint'(period);
        m_n[h] = n_rep == 0 ? 1 : longint'(n_rep);
        for (int i = 0; i < N; i++) begin
          m_d[h][i] = longint'(delay[i*CW +: CW]);
          m_w[h][i] = longint'(width[i*CW +: CW]);
        end
      end else if (fin) begin
        m_mode[h] = h == 1 ? 2 : 0;
        m_hend[h] = cyc + 4;
      end else if (m_mode[h] == 2 && cyc == m_hend[h]) m_mode[h] = 0;
      m_rep[h] = m_mode[h] == 1 ? (cyc - m_t0[h]) / m_p[h] : 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int i, longint d, longint w);
    delay[i*CW +: CW] = CW'(d);
    width[i*CW +: CW] = CW'(w);
  endtask

  task automatic idle_all();
    trigger = 0; abort = 1; missed_clr = 1; arm = 1;
    tick();
    abort = 0; missed_clr = 0;
    tick();
    for (int i = 0; i < N; i++) set_ch(i, 0, 0);
  endtask

  task automatic launch();
    trigger = 1;
    tick();
    trigger = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; trigger = 1; arm = 1;
    set_ch(0, 0, 2); period = 4; n_rep = 1;
    repeat (3) tick();
    tests++;
    if (got_v[0] !== 23'd0) begin fails++; $display("FAIL reset_state got=%h exp=0", got_v[0]); end
    for (int h = 0; h < 2; h++) begin
      tests++;
      if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL reset_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
    end
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (busy_o[0] !== 1'b0 || pulse_o[0] !== 4'b0) begin fails++; $display("FAIL held_trigger busy=%b pulse=%b exp busy=0 pulse=0", busy_o[0], pulse_o[0]); end
    end
    trigger = 0;
    tick();
    launch();
    tests++;
    if (busy_o[0] !== 1'b1) begin fails++; $display("FAIL trigger_after_release busy=%b exp=1", busy_o[0]); end
    for (int h = 0; h < 2; h++) begin
      tests++;
      if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL reset_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
    end
  endtask

  task automatic test_basic();
    logic exp_p;
    idle_all();
    set_ch(0, 2, 3); period = 10; n_rep = 3; retrig_en = 0;
    launch();
    for (int k = 1; k <= 36; k++) begin
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL basic_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
      end
      exp_p = k <= 30 && (k - 1) % 10 >= 2 && (k - 1) % 10 <= 4;
      tests++;
      if (pulse_o[0][0] !== exp_p) begin fails++; $display("FAIL basic_pulse0 k=%0d got=%b exp=%b", k, pulse_o[0][0], exp_p); end
      tests++;
      if (done_o[0] !== (k == 30)) begin fails++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done_o[0], k == 30); end
      tests++;
      if (busy_o[0] !== (k < 30)) begin fails++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy_o[0], k < 30); end
      tests++;
      if (rep_o[0] !== RW'(k < 30 ? k / 10 : 0)) begin fails++; $display("FAIL basic_rep k=%0d got=%0d exp=%0d", k, rep_o[0], k < 30 ? k / 10 : 0); end
      tests++;
      if (busy_o[1] !== (k < 34)) begin fails++; $display("FAIL basic_busy_hold k=%0d got=%b exp=%b", k, busy_o[1], k < 34); end
    end
  endtask

  task automatic test_mixed();
    idle_all();
    set_ch(0, 0, 1); set_ch(1, 1, 0); set_ch(2, 6, 5); set_ch(3, 9, 3);
    period = 8; n_rep = 1;
    launch();
    for (int k = 1; k <= 14; k++) begin
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL mixed_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
      end
      tests++;
      if (pulse_o[0] !== {1'b0, k == 7 || k == 8, 1'b0, k == 1}) begin fails++; $display("FAIL mixed_pulse k=%0d got=%b", k, pulse_o[0]); end
      tests++;
      if (done_o[0] !== (k == 8)) begin fails++; $display("FAIL mixed_done k=%0d got=%b exp=%b", k, done_o[0], k == 8); end
    end
  endtask

  task automatic test_retrig(bit re);
    int j;
    logic exp_p;
    idle_all();
    set_ch(0, 2, 3); period = 10; n_rep = 2; retrig_en = re;
    launch();
    for (int k = 1; k <= 28; k++) begin
      trigger = k == 5;
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL retrig%0d_lockstep cyc=%0d inst=%0d got=%h exp=%h", re, cyc, h, got_v[h], exp_v(h)); end
      end
      j = (re && k > 5) ? k - 5 : k;
      exp_p = j <= 20 && (j - 1) % 10 >= 2 && (j - 1) % 10 <= 4;
      tests++;
      if (pulse_o[0][0] !== exp_p) begin fails++; $display("FAIL retrig%0d_pulse0 k=%0d got=%b exp=%b", re, k, pulse_o[0][0], exp_p); end
      tests++;
      if (done_o[0] !== (k == (re ? 25 : 20))) begin fails++; $display("FAIL retrig%0d_done k=%0d got=%b", re, k, done_o[0]); end
      tests++;
      if (missed_o[0] !== (!re && k >= 5)) begin fails++; $display("FAIL retrig%0d_missed k=%0d got=%b", re, k, missed_o[0]); end
    end
    trigger = 0; missed_clr = 1;
    tick();
    missed_clr = 0;
    tests++;
    if (missed_o[0] !== 1'b0) begin fails++; $display("FAIL missed_clear got=%b exp=0", missed_o[0]); end
  endtask

  task automatic test_holdoff();
    idle_all();
    set_ch(0, 0, 1); period = 3; n_rep = 1; retrig_en = 0;
    launch();
    for (int k = 1; k <= 16; k++) begin
      trigger = k == 5 || k == 8;
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL holdoff_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
      end
      tests++;
      if (busy_o[1] !== (k != 7 && k < 15)) begin fails++; $display("FAIL holdoff_busy k=%0d got=%b", k, busy_o[1]); end
      tests++;
      if (missed_o[1] !== (k >= 5)) begin fails++; $display("FAIL holdoff_missed k=%0d got=%b", k, missed_o[1]); end
      tests++;
      if (done_o[1] !== (k == 3 || k == 11)) begin fails++; $display("FAIL holdoff_done k=%0d got=%b", k, done_o[1]); end
    end
    trigger = 0;
  endtask

  task automatic test_abort();
    idle_all();
    set_ch(0, 1, 6); period = 10; n_rep = 2; retrig_en = 1;
    launch();
    for (int k = 1; k <= 25; k++) begin
      abort = k == 4;
      trigger = k >= 4 && k <= 6;
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL abort_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
      end
      tests++;
      if (k == 3 && pulse_o[0][0] !== 1'b1) begin fails++; $display("FAIL abort_midgate got=%b exp=1", pulse_o[0][0]); end
      tests++;
      if (busy_o[0] !== (k < 4)) begin fails++; $display("FAIL abort_busy k=%0d got=%b", k, busy_o[0]); end
      tests++;
      if (k >= 5 && pulse_o[0] !== 4'b0) begin fails++; $display("FAIL abort_pulse k=%0d got=%b exp=0", k, pulse_o[0]); end
      tests++;
      if (done_o[0] !== 1'b0) begin fails++; $display("FAIL abort_done k=%0d got=%b exp=0", k, done_o[0]); end
    end
    abort = 0; trigger = 0;
  endtask

  task automatic test_random();
    idle_all();
    for (int k = 0; k < 1500; k++) begin
      trigger = $urandom_range(0, 9) == 0;
      arm = $urandom_range(0, 7) != 0;
      abort = $urandom_range(0, 80) == 0;
      retrig_en = 1'($urandom_range(0, 1));
      missed_clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 3) == 0) begin
        period = CW'($urandom_range(0, 12));
        n_rep = RW'($urandom_range(0, 3));
        for (int i = 0; i < N; i++)
          set_ch(i, $urandom_range(0, 13), $urandom_range(0, 9) == 0 ? 64'hFFFF_FFF0 : longint'($urandom_range(0, 13)));
      end
      tick();
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (got_v[h] !== exp_v(h)) begin fails++; $display("FAIL random_lockstep cyc=%0d inst=%0d got=%h exp=%h", cyc, h, got_v[h], exp_v(h)); end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; trig_prev = 0;
    rst_n = 0; arm = 1; trigger = 0; abort = 0; retrig_en = 0; missed_clr = 0;
    delay = '0; width = '0; period = 1; n_rep = 1;
    for (int h = 0; h < 2; h++) begin
      m_mode[h] = 0; m_t0[h] = 0; m_hend[h] = 0; m_p[h] = 1; m_n[h] = 1; m_rep[h] = 0;
      m_pulse[h] = '0; m_done[h] = 0; m_missed[h] = 0;
      for (int i = 0; i < N; i++) begin m_d[h][i] = 0; m_w[h][i] = 0; end
    end
    test_reset();
    test_basic();
    test_mixed();
    test_retrig(1'b0);
    test_retrig(1'b1);
    test_holdoff();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_gate_delay_gen.md
Name: multi_gate_delay_gen

Overview:
Parametrised multi-channel gate/delay generator and successor to the single-channel pulse generator. A single trigger rising edge launches a burst of n_rep periods. In every period each of N_CH channels emits one gate at its own delay and width. Adds arming, abort, optional retrigger, post-run hold-off, missed-trigger flag and a done strobe. Sits between trigger-conditioning logic and detector/laser gate outputs in the experiment timing fabric.

Parameters:
N_CH, 4, number of independent gate channels
CNT_W, 32, width of delay/width/period values and cycle counter
REP_W, 16, width of repetition count and index
HOLDOFF, 0, clk cycles after burst end during which triggers are refused (0 = none)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
arm  in  1  1 = trigger edges accepted from IDLE
trigger  in  1  start input, synchronous to clk (synchroniser is upstream)
abort  in  1  1 = terminate burst at next edge
retrig_en  in  1  1 = trigger edge during RUN restarts burst
missed_clr  in  1  clears missed flag
delay  in  N_CH*CNT_W  per-channel delay; channel i at bits [i*CNT_W +: CNT_W]
width  in  N_CH*CNT_W  per-channel gate width, same packing
period  in  CNT_W  burst period in cycles
n_rep  in  REP_W  number of periods in burst
pulse  out  N_CH  registered gate outputs
busy  out  1  high in RUN or HOLDOFF
rep_idx  out  REP_W  current period index within burst
done  out  1  one-cycle strobe at burst completion
missed  out  1  sticky: an armed trigger edge was refused

Behaviour:
- One clock; reset is synchronous and active-low. With rst_n=0 at an edge: state=IDLE; cnt, rep_idx, pulse, done, missed=0; busy=0. trig_d loads the current trigger value, so a trigger held high through reset release does not fire.
- Edge detect: trig_edge = trigger & ~trig_d; trig_d <= trigger every cycle.
- States: IDLE, RUN, HOLD.
- IDLE -> RUN on edge E0 with trig_edge & arm & ~abort. At E0: cnt<=0, rep<=0. Shadow registers latch delay, width, period_eff = max(period,1) and nrep_eff = max(n_rep,1). Input changes during RUN are ignored.
- RUN, each edge: if cnt == period_eff-1, then cnt<=0 and rep<=rep+1, else cnt<=cnt+1.
- RUN end: at the edge where cnt==period_eff-1 and rep==nrep_eff-1, go to HOLD (HOLDOFF>0) or IDLE, and done<=1 for one cycle.
- HOLD: hold counter runs for HOLDOFF cycles, then IDLE. busy=1 throughout.
- Gate window for channel i: (cnt >= d_i) & (cnt < d_i + w_i). The sum is computed in CNT_W+1 bits, so it never wraps. The window is naturally clipped at period_eff.
- Each edge: pulse[i] <= (state==RUN) & window_i, evaluated on pre-edge values. The gate therefore first rises after edge E(d+1) relative to E0, is high exactly w cycles, and repeats every period_eff cycles.
- Width 0, or delay >= period_eff: channel stays low and the burst still completes.
- abort=1 at any edge has priority over all events: state<=IDLE, cnt/rep<=0, no done. pulse is low from the following edge.
- Trigger edge in RUN:
  - retrig_en=1: restart exactly as at E0 (new shadows, rep=0), no done.
  - retrig_en=0: ignore and set missed.
- Trigger edge in HOLD with arm=1: ignore and set missed.
- Trigger edge with arm=0: ignored, missed unchanged.
- missed is cleared by missed_clr. A set event in the same cycle wins over clear.
- rep_idx = rep register; 0 in IDLE.

Test Plan:
- Reset with trigger held 1, release rst_n -> no burst, busy=0, pulse=0. Then drop and raise trigger -> burst starts.
- CH0 d=2 w=3, period=10, n_rep=3, HOLDOFF=0, one trigger edge at E0:
  - pulse[0] high after E3,E13,E23 for 3 cycles each.
  - done high for the cycle after E30; busy falls at E30; rep_idx steps 0,1,2.
- Mixed channels, period=8, n_rep=1: CH1 w=0; CH2 d=6 w=5 (clipped to 2 cycles, E7..E8); CH3 d=9 (never high) -> done still strobes after E8.
- Second trigger edge at E5 of a burst:
  - retrig_en=0 -> burst unaffected, missed=1 until missed_clr.
  - retrig_en=1 -> counters restart at E5; pulse[0] (d=2) next rises after E8; done timing shifts by 5.
- HOLDOFF=4: trigger 2 cycles after done -> refused, missed=1. Trigger at done+5 -> accepted.
- abort asserted mid-gate with trigger in the same cycle -> state IDLE, pulse low next cycle, no done, no new burst.
